// File: rtl/rvvi_tx_scheduler.sv
// Arbitrates the RVVI Ethernet TX register between fresh packets and active-list replays,
// enforcing an outstanding-packet cap, replay starvation limit and ack-timeout watchdog.
module rvvi_tx_scheduler #(
   parameter int WIDTH   = 792,
   parameter int MAXOUT  = 8,
   parameter int TIMEOUT = 1023,
   parameter int STARVE  = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         NewValid,
   input  logic [WIDTH-1:0]             NewData,
   output logic                         NewReady,
   input  logic                         RepValid,
   input  logic [WIDTH-1:0]             RepData,
   output logic                         RepStall,
   input  logic                         AckValid,
   input  logic                         AlFull,
   output logic                         TxValid,
   output logic [WIDTH-1:0]             TxData,
   output logic                         TxIsReplay,
   input  logic                         TxReady,
   output logic                         TimeoutReplay,
   output logic [$clog2(MAXOUT+1)-1:0]  Outstanding
);

   localparam int OW = $clog2(MAXOUT + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam int SW = $clog2(STARVE + 1);
   localparam logic [OW-1:0] MAXOUT_C = OW'(MAXOUT);
   localparam logic [TW-1:0] TLAST_C  = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

   logic             tx_valid_q, tx_valid_d;
   logic [WIDTH-1:0] tx_data_q, tx_data_d;
   logic             tx_rep_q, tx_rep_d;
   logic [OW-1:0]    out_q, out_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             tmo_q, tmo_d;

   logic slot_free, new_elig, new_turn, stall_int;
   logic rep_grant, new_grant, ack_dec, wd_clear;

   assign slot_free = ~tx_valid_q | TxReady;
   assign new_elig  = NewValid & ~AlFull & (out_q < MAXOUT_C);
   assign new_turn  = new_elig & (starve_q == STARVE_C);
   // Built only from registered state and fresh-side inputs so it never loops through RepValid.
   assign stall_int = ~slot_free | new_turn;
   assign rep_grant = reset_n & RepValid & ~stall_int;
   assign new_grant = reset_n & new_elig & slot_free & ~RepValid;
   assign ack_dec   = AckValid & (out_q != '0);
   assign wd_clear  = AckValid | (out_q == '0) | rep_grant;

   assign NewReady      = new_grant;
   assign RepStall      = reset_n & stall_int;
   assign TxValid       = tx_valid_q;
   assign TxData        = tx_data_q;
   assign TxIsReplay    = tx_rep_q;
   assign TimeoutReplay = tmo_q;
   assign Outstanding   = out_q;

   always_comb begin
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      tx_rep_d   = tx_rep_q;
      if (rep_grant) begin
         tx_valid_d = 1'b1;
         tx_data_d  = RepData;
         tx_rep_d   = 1'b1;
      end else if (new_grant) begin
         tx_valid_d = 1'b1;
         tx_data_d  = NewData;
         tx_rep_d   = 1'b0;
      end else if (slot_free) begin
         tx_valid_d = 1'b0;
      end

      starve_d = starve_q;
      if (!new_elig || new_grant) begin
         starve_d = '0;
      end else if (rep_grant && (starve_q != STARVE_C)) begin
         starve_d = starve_q + SW'(1);
      end

      out_d = out_q;
      case ({new_grant, ack_dec})
         2'b10:   out_d = out_q + OW'(1);
         2'b01:   out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase

      // Timer holds while a replay is being offered; the replay itself will clear it.
      timer_d = timer_q;
      tmo_d   = 1'b0;
      if (wd_clear) begin
         timer_d = '0;
      end else if (!RepValid) begin
         if (timer_q == TLAST_C) begin
            timer_d = '0;
            tmo_d   = 1'b1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         tx_rep_q   <= 1'b0;
         out_q      <= '0;
         starve_q   <= '0;
         timer_q    <= '0;
         tmo_q      <= 1'b0;
      end else begin
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         tx_rep_q   <= tx_rep_d;
         out_q      <= out_d;
         starve_q   <= starve_d;
         timer_q    <= timer_d;
         tmo_q      <= tmo_d;
      end
   end

endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
// Directed bench for rvvi_tx_scheduler with a TX scoreboard fed by accepted fresh/replay beats.
module tb_rvvi_tx_scheduler;

   localparam int W  = 64;
   localparam int MO = 8;
   localparam int TO = 16;
   localparam int ST = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          NewValid, NewReady, RepValid, RepStall, AckValid, AlFull;
   logic [W-1:0]  NewData, RepData, TxData;
   logic          TxValid, TxIsReplay, TxReady, TimeoutReplay;
   logic [3:0]    Outstanding;

   int checks = 0;
   int errors = 0;
   int n;

   typedef struct packed {
      logic [W-1:0] d;
      logic         r;
   } beat_t;
   beat_t sb[$];
   beat_t exp_b;

   rvvi_tx_scheduler #(.WIDTH(W), .MAXOUT(MO), .TIMEOUT(TO), .STARVE(ST)) dut (
      .clk(clk), .reset_n(reset_n),
      .NewValid(NewValid), .NewData(NewData), .NewReady(NewReady),
      .RepValid(RepValid), .RepData(RepData), .RepStall(RepStall),
      .AckValid(AckValid), .AlFull(AlFull),
      .TxValid(TxValid), .TxData(TxData), .TxIsReplay(TxIsReplay), .TxReady(TxReady),
      .TimeoutReplay(TimeoutReplay), .Outstanding(Outstanding)
   );

   always #5 clk = ~clk;

   task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic acks(input int k);
      AckValid = 1'b1;
      repeat (k) tick();
      AckValid = 1'b0;
   endtask

   // Scoreboard: push accepted beats, pop on each TX handshake; reset drops everything held.
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
      end else begin
         if (TxValid && TxReady) begin
            if (sb.size() == 0) begin
               check1("sb_underflow", 1'b1, 1'b0);
            end else begin
               exp_b = sb.pop_front();
               checkw("sb_txdata", TxData, exp_b.d);
               check1("sb_txrep", TxIsReplay, exp_b.r);
            end
         end
         if (RepValid) begin
            check1("rep_protocol_stall", RepStall, 1'b0);
            sb.push_back({RepData, 1'b1});
         end
         if (NewValid && NewReady) sb.push_back({NewData, 1'b0});
      end
   end

   initial begin
      reset_n = 1'b0; NewValid = 1'b1; NewData = '0; RepValid = 1'b0; RepData = '0;
      AckValid = 1'b0; AlFull = 1'b0; TxReady = 1'b1;
      @(negedge clk);
      check1("rst_newready", NewReady, 1'b0);
      check1("rst_repstall", RepStall, 1'b0);
      tick(); tick();
      check1("rst_txvalid", TxValid, 1'b0);
      check1("rst_txrep", TxIsReplay, 1'b0);
      checkw("rst_txdata", TxData, '0);
      checkw("rst_out", W'(Outstanding), W'(0));
      check1("rst_tmo", TimeoutReplay, 1'b0);
      reset_n = 1'b1; NewValid = 1'b0;
      tick();

      // Basic flow
      for (int i = 0; i < 3; i++) begin
         NewValid = 1'b1; NewData = W'(64'h1000 + i);
         @(negedge clk); check1("t1_newready", NewReady, 1'b1);
         tick();
         check1("t1_txvalid", TxValid, 1'b1);
         check1("t1_txrep", TxIsReplay, 1'b0);
      end
      NewValid = 1'b0;
      checkw("t1_out", W'(Outstanding), W'(3));
      NewValid = 1'b1; NewData = 64'h1003; AckValid = 1'b1;
      @(negedge clk); check1("t1_ga_ready", NewReady, 1'b1);
      tick();
      checkw("t1_grant_ack_out", W'(Outstanding), W'(3));
      NewValid = 1'b0; AckValid = 1'b0;
      @(negedge clk); check1("t1_idle_ready", NewReady, 1'b0);
      tick();
      check1("t1_drained", TxValid, 1'b0);
      acks(3);
      checkw("t1_out_zero", W'(Outstanding), W'(0));
      acks(1);
      checkw("t1_ack_at_zero", W'(Outstanding), W'(0));

      // Credit cap
      NewValid = 1'b1; n = 0;
      for (int i = 0; i < 12; i++) begin
         NewData = W'(64'h2000 + i);
         @(negedge clk); if (NewReady) n++;
         tick();
      end
      checkw("t2_grants", W'(n), W'(8));
      checkw("t2_out_cap", W'(Outstanding), W'(MO));
      @(negedge clk); check1("t2_cap_ready", NewReady, 1'b0);
      tick();
      RepValid = 1'b1; RepData = 64'h2A00;
      @(negedge clk); check1("t2_cap_repstall", RepStall, 1'b0);
      tick();
      RepValid = 1'b0;
      check1("t2_cap_replay", TxIsReplay, 1'b1);
      checkw("t2_cap_replay_out", W'(Outstanding), W'(MO));
      acks(1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         NewData = W'(64'h2100 + i);
         @(negedge clk); if (NewReady) n++;
         tick();
      end
      checkw("t2_after_ack_grants", W'(n), W'(1));
      checkw("t2_after_ack_out", W'(Outstanding), W'(MO));
      NewValid = 1'b0;
      acks(8);
      checkw("t2_out_zero", W'(Outstanding), W'(0));
      AlFull = 1'b1; NewValid = 1'b1; NewData = 64'h2F00;
      @(negedge clk); check1("t2_alfull_ready", NewReady, 1'b0);
      tick(); tick();
      checkw("t2_alfull_out", W'(Outstanding), W'(0));
      AlFull = 1'b0; NewValid = 1'b0;
      tick();

      // Starvation: four replays then one fresh, repeating
      NewValid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         NewData  = W'(64'h3000 + i);
         RepData  = W'(64'h3800 + i);
         RepValid = ((i % 5) != 4);
         @(negedge clk);
         check1("t3_repstall", RepStall, (i % 5) == 4);
         check1("t3_newready", NewReady, (i % 5) == 4);
         tick();
         check1("t3_kind", TxIsReplay, (i % 5) != 4);
      end
      NewValid = 1'b0; RepValid = 1'b0;
      checkw("t3_out", W'(Outstanding), W'(3));
      acks(3);

      // Backpressure
      NewValid = 1'b1; NewData = 64'h4000;
      @(negedge clk);
      tick();
      TxReady = 1'b0; NewData = 64'h4001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check1("t4_hold_valid", TxValid, 1'b1);
         checkw("t4_hold_data", TxData, 64'h4000);
         check1("t4_repstall", RepStall, 1'b1);
         check1("t4_newready", NewReady, 1'b0);
         tick();
      end
      TxReady = 1'b1;
      @(negedge clk); check1("t4_drain_ready", NewReady, 1'b1);
      tick();
      checkw("t4_next_data", TxData, 64'h4001);
      NewValid = 1'b0;
      tick();
      checkw("t4_out", W'(Outstanding), W'(2));
      acks(2);

      // Ack timeout
      NewValid = 1'b1; NewData = 64'h5000;
      @(negedge clk);
      tick();
      NewValid = 1'b0; n = 0;
      while (!TimeoutReplay && n < 40) begin tick(); n++; end
      checkw("t5_first_pulse", W'(n), W'(TO));
      tick();
      check1("t5_pulse_width", TimeoutReplay, 1'b0);
      n = 1;
      while (!TimeoutReplay && n < 40) begin tick(); n++; end
      checkw("t5_period", W'(n), W'(TO));
      acks(1);
      NewValid = 1'b1; NewData = 64'h5001;
      @(negedge clk);
      tick();
      NewValid = 1'b0; n = 0;
      repeat (10) begin tick(); if (TimeoutReplay) n++; end
      acks(1);
      repeat (30) begin tick(); if (TimeoutReplay) n++; end
      checkw("t5_no_pulse", W'(n), W'(0));
      checkw("t5_out", W'(Outstanding), W'(0));

      // Reset with a held packet
      for (int i = 0; i < 5; i++) begin
         NewValid = 1'b1; NewData = W'(64'h6000 + i);
         @(negedge clk);
         tick();
      end
      NewValid = 1'b0; TxReady = 1'b0;
      checkw("t6_out_pre", W'(Outstanding), W'(5));
      check1("t6_valid_pre", TxValid, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      check1("t6_rst_newready", NewReady, 1'b0);
      check1("t6_rst_repstall", RepStall, 1'b0);
      tick();
      check1("t6_txvalid", TxValid, 1'b0);
      checkw("t6_out", W'(Outstanding), W'(0));
      check1("t6_tmo", TimeoutReplay, 1'b0);
      check1("t6_txrep", TxIsReplay, 1'b0);
      checkw("t6_txdata", TxData, '0);
      reset_n = 1'b1; TxReady = 1'b1;
      tick(); tick();
      checkw("sb_empty", W'(sb.size()), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvvi_tx_scheduler.md
Name: rvvi_tx_scheduler

Overview:
- Shares the single RVVI Ethernet transmit path between two sources:
  - fresh trace packets from the RVVI packetizer;
  - replayed packets read out of the RVVI active list's port 3.
- Enforces a cap on unacknowledged packets.
- Runs an ack-timeout watchdog that asks the active list to replay when the host goes silent.
- Sits between the packetizer/active list and the Ethernet MAC TX interface.

Parameters:
- WIDTH, 792, packet payload width in bits.
- MAXOUT, 8, maximum outstanding (sent, unacked) fresh packets; at least 1.
- TIMEOUT, 1023, ack-timeout cycles; at least 2.
- STARVE, 4, maximum consecutive replay grants while a fresh packet is eligible.

Ports:
- clk  in  1  clock.
- reset_n  in  1  one clock; reset is synchronous and active-low.
- NewValid  in  1  fresh packet available.
- NewData  in  WIDTH  fresh packet.
- NewReady  out  1  fresh packet accepted this cycle.
- RepValid  in  1  replay beat from active list; only asserted in a cycle where RepStall=0.
- RepData  in  WIDTH  replay packet.
- RepStall  out  1  to active list Port3Stall.
- AckValid  in  1  one ack received (active list port-2 write).
- AlFull  in  1  active list full.
- TxValid  out  1  packet valid to MAC.
- TxData  out  WIDTH  packet to MAC.
- TxIsReplay  out  1  current TxData is a replay.
- TxReady  in  1  MAC accepts.
- TimeoutReplay  out  1  one-cycle replay request to active list.
- Outstanding  out  $clog2(MAXOUT+1)  unacked fresh packet count.

Behaviour:
- Output register
  - TxValid, TxData and TxIsReplay are registered.
  - Once TxValid=1, these three hold stable until TxValid&TxReady.
  - SlotFree = ~TxValid | TxReady.
  - A grant loads the register at the next edge; grant-to-TxValid latency is 1 cycle.
  - If no grant occurs while SlotFree, TxValid falls to 0.
- Eligibility: NewElig = NewValid & ~AlFull & (Outstanding < MAXOUT).
- Starvation
  - NewTurn = NewElig & (StarveCnt == STARVE).
  - StarveCnt increments on a replay grant when NewElig=1.
  - StarveCnt clears on a fresh grant or on any cycle with NewElig=0.
  - StarveCnt saturates at STARVE.
- RepStall
  - RepStall = ~SlotFree | NewTurn.
  - RepStall must not depend combinationally on RepValid; this avoids a loop with the active list.
- Grant priority
  - If RepValid: grant replay. Acceptance is guaranteed because RepValid implies RepStall=0.
  - Else if NewElig & SlotFree: grant fresh, with NewReady=1.
  - NewReady = SlotFree & NewElig & ~RepValid.
  - When NewTurn=1, RepStall=1, so RepValid=0 and the fresh packet wins.
- Outstanding counter
  - +1 on fresh grant; -1 on AckValid when nonzero.
  - Simultaneous grant and ack leaves it unchanged.
  - AckValid at 0 is ignored (saturate).
  - Replays never change Outstanding.
- Watchdog timer
  - Clears on AckValid, on Outstanding==0, or on any replay grant.
  - Otherwise increments each cycle.
  - When the timer reaches TIMEOUT-1 and the increment condition holds, TimeoutReplay=1 for exactly that cycle and the timer clears to 0.
  - TimeoutReplay is suppressed (and the timer held) while RepValid=1.
- Reset
  - On reset_n=0 at an edge: TxValid=0, TxIsReplay=0, TxData=0, Outstanding=0, StarveCnt=0, timer=0, TimeoutReplay=0.
  - Mid-transfer reset drops the held packet without a handshake; MAC-side tolerance is the integrator's responsibility.
  - During reset: NewReady=0, RepStall=0.
- Boundaries
  - Outstanding==MAXOUT blocks fresh traffic; replays still flow.
  - AlFull blocks fresh traffic.
  - TxReady held low stalls both sources; RepStall=1 and NewReady=0 throughout.

Test Plan:
1. Basic flow: TxReady=1, NewValid=1 for 3 cycles, no acks → 3 packets on Tx with TxIsReplay=0; Outstanding=3; NewReady high for 3 cycles.
2. Credit cap: MAXOUT=8, no acks, NewValid held → exactly 8 fresh grants, then NewReady=0. One AckValid → exactly one more grant; Outstanding returns to 8.
3. Starvation: NewValid=1 and RepValid asserted whenever RepStall=0 → pattern of 4 replays, 1 fresh, repeating. RepStall=1 in each fresh-grant cycle.
4. Backpressure: TxReady=0 for 5 cycles with the register loaded → TxData stable, RepStall=1, NewReady=0; data drains on the first TxReady=1 cycle.
5. Timeout: TIMEOUT=16, one fresh packet sent, no ack → TimeoutReplay pulses 16 cycles after the count starts, then every 16 cycles. An ack before cycle 16 → no pulse and Outstanding=0.
6. Reset: reset_n low with TxValid=1 and Outstanding=5 → next cycle TxValid=0, Outstanding=0, TimeoutReplay=0.
